// File: rtl/led_bank_arbiter_if.sv
// rtl/led_bank_arbiter_if.sv - source/arbiter signal bundle for the shared LED bank
interface led_bank_arbiter_if;
  logic [2:0] req;
  logic [2:0] rel;
  logic [3:0] pat0;
  logic [3:0] pat1;
  logic [3:0] pat2;
  logic [2:0] gnt;
  logic [1:0] owner;
  logic [3:0] LED;
  logic       tick;

  modport master (
    output req, rel, pat0, pat1, pat2,
    input  gnt, owner, LED, tick
  );

  modport slave (
    input  req, rel, pat0, pat1, pat2,
    output gnt, owner, LED, tick
  );
endinterface

// File: rtl/led_bank_arbiter.sv
// rtl/led_bank_arbiter.sv - round-robin LED bank arbiter with min/max hold and tick prescaler
// Define LED_ARB_BLANK_EN to blank the bank (GAP state) for up to one tick between owners.
module led_bank_arbiter #(
  parameter int TICK_DIV = 13500000,
  parameter int MIN_HOLD = 2,
  parameter int MAX_HOLD = 8
) (
  input logic               clk,
  input logic               rst,
  led_bank_arbiter_if.slave bus
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MIN  = HW'(MIN_HOLD);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);

  typedef enum logic [1:0] {S_IDLE, S_OWNED, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rel_pend_q, rel_pend_d;
  logic [1:0]    last_q, last_d;
  logic [3:0]    led_q, led_d;

  logic [HW-1:0] hold_next;
  logic [3:0]    owner_pat;
  logic [2:0]    owner_oh;
  logic [1:0]    cand1, cand2, pick;
  logic          pick_valid;
  logic          want_rel, competitor, do_release;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pre_q      <= '0;
      tick_q     <= 1'b0;
      hold_q     <= '0;
      rel_pend_q <= 1'b0;
      last_q     <= 2'd2;
      led_q      <= 4'h0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      tick_q     <= tick_d;
      hold_q     <= hold_d;
      rel_pend_q <= rel_pend_d;
      last_q     <= last_d;
      led_q      <= led_d;
    end
  end

  // last_q doubles as the current owner while OWNED and as the fairness pointer otherwise
  always_comb begin
    owner_oh  = 3'b000;
    owner_pat = 4'h0;
    case (last_q)
      2'd0: begin owner_oh = 3'b001; owner_pat = bus.pat0; end
      2'd1: begin owner_oh = 3'b010; owner_pat = bus.pat1; end
      2'd2: begin owner_oh = 3'b100; owner_pat = bus.pat2; end
      default: begin owner_oh = 3'b000; owner_pat = 4'h0; end
    endcase
  end

  always_comb begin
    cand1      = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    cand2      = (last_q == 2'd0) ? 2'd2 : last_q - 2'd1;
    pick       = last_q;
    pick_valid = 1'b1;
    if (bus.req[cand1])       pick = cand1;
    else if (bus.req[cand2])  pick = cand2;
    else if (bus.req[last_q]) pick = last_q;
    else                      pick_valid = 1'b0;
  end

  // Release decisions look at the post-tick hold count so same-edge ticks count
  always_comb begin
    hold_next  = (tick_q && (hold_q != HOLD_MAX)) ? hold_q + 1'b1 : hold_q;
    want_rel   = bus.rel[last_q] | ~bus.req[last_q] | rel_pend_q;
    competitor = |(bus.req & ~owner_oh);
    do_release = (want_rel && (hold_next >= HOLD_MIN)) ||
                 ((hold_next == HOLD_MAX) && competitor);
  end

  always_comb begin
    pre_d      = (pre_q == TICK_LAST) ? '0 : pre_q + 1'b1;
    tick_d     = (pre_q == TICK_LAST);
    state_d    = state_q;
    hold_d     = hold_q;
    rel_pend_d = rel_pend_q;
    last_d     = last_q;
    led_d      = led_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d = S_OWNED;
          last_d  = pick;
          hold_d  = '0;
        end
      end
      S_OWNED: begin
        led_d  = owner_pat;
        hold_d = hold_next;
        if (do_release) begin
          rel_pend_d = 1'b0;
`ifdef LED_ARB_BLANK_EN
          state_d    = S_GAP;
`else
          state_d    = S_IDLE;
`endif
        end else if (want_rel) begin
          rel_pend_d = 1'b1;
        end
      end
`ifdef LED_ARB_BLANK_EN
      S_GAP: begin
        led_d = 4'h0;
        if (tick_q) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.gnt   = (state_q == S_OWNED) ? owner_oh : 3'b000;
    bus.owner = (state_q == S_OWNED) ? last_q : 2'b11;
    bus.LED   = led_q;
    bus.tick  = tick_q;
  end
endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb/tb_led_bank_arbiter.sv - vector table, directed corner sequences and randomized model check
module tb_led_bank_arbiter;
  localparam int TICK_DIV = 4;
  localparam int MIN_HOLD = 2;
  localparam int MAX_HOLD = 4;
`ifdef LED_ARB_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  led_bank_arbiter_if bus();

  led_bank_arbiter #(
    .TICK_DIV(TICK_DIV),
    .MIN_HOLD(MIN_HOLD),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 owned, 2 blank gap; tick derived from edge count
  int         m_n, m_phase, m_last, m_hold;
  bit         m_pend, m_tick;
  logic [3:0] m_led;

  function automatic logic [3:0] pat_of(input int k);
    if (k == 0) return bus.pat0;
    if (k == 1) return bus.pat1;
    return bus.pat2;
  endfunction

  task automatic model_reset();
    m_n = 0; m_phase = 0; m_last = 2; m_hold = 0;
    m_pend = 0; m_tick = 0; m_led = 4'h0;
  endtask

  task automatic model_edge();
    bit t = m_tick;
    bit found = 0;
    bit want, others;
    int h;
    m_n++;
    if (m_phase == 0) begin
      for (int i = 1; i <= 3; i++)
        if (!found && bus.req[(m_last + i) % 3]) begin
          found = 1;
          m_last = (m_last + i) % 3;
        end
      if (found) begin m_phase = 1; m_hold = 0; end
    end else if (m_phase == 1) begin
      m_led  = pat_of(m_last);
      h      = (t && m_hold < MAX_HOLD) ? m_hold + 1 : m_hold;
      want   = bus.rel[m_last] || !bus.req[m_last] || m_pend;
      others = (bus.req & ~(3'b001 << m_last)) != 3'b000;
      if ((want && h >= MIN_HOLD) || (h == MAX_HOLD && others)) begin
        m_phase = BLANK ? 2 : 0;
        m_pend  = 0;
      end else if (want) begin
        m_pend = 1;
      end
      m_hold = h;
    end else begin
      m_led = 4'h0;
      if (t) m_phase = 0;
    end
    m_tick = (m_n % TICK_DIV) == 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 3'b000;
    bus.rel = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] rel;
    logic [3:0] p0, p1, p2;
    logic [2:0] gnt;
    logic [1:0] own;
    logic [3:0] led;
    logic       tick;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt, e, rel_edge, held;
    logic [2:0]  r;
    logic [2:0]  eg;
    logic [1:0]  eo;

    tbl[0] = '{3'b111, 3'b000, 4'h5, 4'h1, 4'h9, 3'b001, 2'd0, 4'h0, 1'b0};
    tbl[1] = '{3'b111, 3'b000, 4'h5, 4'h1, 4'h9, 3'b001, 2'd0, 4'h5, 1'b0};
    tbl[2] = '{3'b111, 3'b000, 4'hA, 4'h1, 4'h9, 3'b001, 2'd0, 4'hA, 1'b0};
    tbl[3] = '{3'b111, 3'b100, 4'hA, 4'hF, 4'h6, 3'b001, 2'd0, 4'hA, 1'b1};
    tbl[4] = '{3'b111, 3'b000, 4'hA, 4'hF, 4'h6, 3'b001, 2'd0, 4'hA, 1'b0};
    tbl[5] = '{3'b111, 3'b000, 4'h3, 4'hF, 4'h6, 3'b001, 2'd0, 4'h3, 1'b0};

    bus.pat0 = 4'h0; bus.pat1 = 4'h0; bus.pat2 = 4'h0;
    do_reset();
    chk("rst_gnt",   32'(bus.gnt),   32'(3'b000));
    chk("rst_owner", 32'(bus.owner), 32'(2'b11));
    chk("rst_led",   32'(bus.LED),   32'(4'h0));
    chk("rst_tick",  32'(bus.tick),  32'(1'b0));

    for (int i = 0; i < 6; i++) begin
      bus.req = tbl[i].req; bus.rel = tbl[i].rel;
      bus.pat0 = tbl[i].p0; bus.pat1 = tbl[i].p1; bus.pat2 = tbl[i].p2;
      step();
      chk($sformatf("vec%0d_gnt", i),   32'(bus.gnt),   32'(tbl[i].gnt));
      chk($sformatf("vec%0d_owner", i), 32'(bus.owner), 32'(tbl[i].own));
      chk($sformatf("vec%0d_led", i),   32'(bus.LED),   32'(tbl[i].led));
      chk($sformatf("vec%0d_tick", i),  32'(bus.tick),  32'(tbl[i].tick));
    end

    // Early release pulse is latched and honoured when the hold count reaches MIN_HOLD
    bus.rel = 3'b001; step();
    chk("pend_edge7_gnt", 32'(bus.gnt), 32'(3'b001));
    bus.rel = 3'b000; step();
    chk("pend_edge8_gnt", 32'(bus.gnt), 32'(3'b001));
    step();
    chk("rel_edge9_gnt",   32'(bus.gnt),   32'(3'b000));
    chk("rel_edge9_owner", 32'(bus.owner), 32'(2'b11));
    chk("rel_edge9_led",   32'(bus.LED),   32'(4'h3));
`ifdef LED_ARB_BLANK_EN
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("gap%0d_led", k), 32'(bus.LED), 32'(4'h0));
      chk($sformatf("gap%0d_gnt", k), 32'(bus.gnt), 32'(3'b000));
    end
    step();
    chk("after_gap_gnt", 32'(bus.gnt), 32'(3'b010));
    chk("after_gap_led", 32'(bus.LED), 32'(4'h0));
`else
    step();
    chk("handover_gnt", 32'(bus.gnt), 32'(3'b010));
    chk("handover_led", 32'(bus.LED), 32'(4'h3));
`endif
    chk("rr_owner", 32'(bus.owner), 32'(2'd1));
    step();
    chk("owner1_led", 32'(bus.LED), 32'(4'hF));
    bus.pat1 = 4'h8; bus.pat0 = 4'h1; bus.pat2 = 4'h2;
    chk("pat_before_edge", 32'(bus.LED), 32'(4'hF));
    step();
    chk("pat_latency", 32'(bus.LED), 32'(4'h8));

    // Forced release after MAX_HOLD ticks with a competitor present
    do_reset();
    bus.req = 3'b110; step(); e = 1;
    chk("forced_grant", 32'(bus.gnt), 32'(3'b010));
    cnt = bus.tick ? 1 : 0;
    rel_edge = 0;
    for (int k = 0; k < 40 && rel_edge == 0; k++) begin
      step(); e++;
      if (bus.gnt == 3'b010) begin
        if (bus.tick) cnt++;
      end else rel_edge = e;
    end
    chk("forced_ticks", 32'(cnt), 32'(MAX_HOLD));
    chk("forced_edge",  32'(rel_edge), 32'(17));
    for (int k = 0; k < 20 && bus.gnt == 3'b000; k++) step();
    chk("rr_after_forced", 32'(bus.gnt), 32'(3'b100));

    bus.req = 3'b100;
    held = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus.gnt == 3'b100) held++;
    end
    chk("retain_alone", 32'(held), 32'(30));
    bus.rel = 3'b100; step();
    chk("owner_rel", 32'(bus.gnt), 32'(3'b000));
    bus.rel = 3'b000; bus.req = 3'b000;

    // Asynchronous reset between edges while a tick is high and source 0 owns
    do_reset();
    bus.pat0 = 4'hF; bus.req = 3'b001; step();
    chk("pre_rst_gnt", 32'(bus.gnt), 32'(3'b001));
    for (int k = 0; k < 10 && !bus.tick; k++) step();
    chk("pre_rst_led", 32'(bus.LED), 32'(4'hF));
    #1 rst = 1'b1;
    #1;
    chk("async_led",   32'(bus.LED),   32'(4'h0));
    chk("async_gnt",   32'(bus.gnt),   32'(3'b000));
    chk("async_owner", 32'(bus.owner), 32'(2'b11));
    chk("async_tick",  32'(bus.tick),  32'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus.req = 3'b110; step();
    chk("post_rst_rr", 32'(bus.gnt), 32'(3'b010));

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      r = bus.req;
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      bus.req = r;
      for (int b = 0; b < 3; b++) r[b] = ($urandom_range(0, 9) == 0);
      bus.rel = r;
      if ($urandom_range(0, 3) == 0) bus.pat0 = 4'($urandom);
      if ($urandom_range(0, 3) == 0) bus.pat1 = 4'($urandom);
      if ($urandom_range(0, 3) == 0) bus.pat2 = 4'($urandom);
      step();
      eg = (m_phase == 1) ? 3'(3'b001 << m_last) : 3'b000;
      eo = (m_phase == 1) ? 2'(m_last) : 2'b11;
      chk($sformatf("rand%0d", c), 32'({bus.gnt, bus.owner, bus.LED, bus.tick}),
          32'({eg, eo, m_led, m_tick}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/led_bank_arbiter.md
# led_bank_arbiter

Time-shares the board's single 4-bit LED bank between three pattern sources: the DIP-unlock sweep, the error blink and the push-button mirror. Each source raises a request and drives its own 4-bit pattern. The arbiter grants the bank round-robin, enforces minimum and maximum ownership times, and registers the winner's pattern onto `LED`. It also hosts the slow-tick prescaler, which it exports as a clock-enable so the sources need no derived clock.

## Interface
- `TICK_DIV`, 13500000: clk cycles per tick; legal values are ≥2.
- `MIN_HOLD`, 2: ticks a grant is guaranteed before release is honoured; legal range 1..MAX_HOLD.
- `MAX_HOLD`, 8: ticks after which the grant is forcibly removed if another source is requesting.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  3  per-source request, level; bit i = source i.
- `rel`  in  3  per-source release pulse; only the owner's bit is honoured.
- `pat0`, `pat1`, `pat2`  in  4 each  pattern of sources 0/1/2.
- `gnt`  out  3  one-hot grant; 000 when no owner.
- `owner`  out  2  index of the current owner; 2'b11 when none.
- `LED`  out  4  registered LED drive.
- `tick`  out  1  one-clk pulse every TICK_DIV clks.

## Operation
- **Prescaler:** the counter runs 0..TICK_DIV-1 and wraps. `tick` is registered and asserts for one clk each time the counter wraps.
- **State machine:** IDLE, OWNED, GAP.
- **IDLE**
  - `gnt`=000, `owner`=3, `LED` holds its last value.
  - If any `req` bit is set, pick the first requester in round-robin order `last+1`, `last+2`, `last+3` (mod 3).
  - On that pick: go to OWNED, set `owner`, `last`, and `gnt`; clear `hold_cnt` to 0.
- **OWNED**
  - Every clk: `LED <= pat[owner]`.
  - `hold_cnt` increments on each `tick` and saturates at MAX_HOLD.
  - *Voluntary release:* (`rel[owner]` pulse or `req[owner]`=0) with `hold_cnt` ≥ MIN_HOLD. A release request seen before MIN_HOLD is latched in `rel_pend` and acted on once MIN_HOLD is reached. `rel_pend` clears on leaving OWNED.
  - *Forced release:* `hold_cnt`==MAX_HOLD and some other `req` bit is set.
  - If no other source is requesting, the owner keeps the bank indefinitely after MAX_HOLD.
  - On release: `gnt`=000 and `owner`=3 from the next clk, then go to GAP.
- **GAP:** `LED`=0000 and requests are ignored. Leave for IDLE on the next `tick`.
- **Fairness:** `last` records the most recent owner, so a released source has lowest priority in the next arbitration.
- `rel` bits from non-owners are ignored. `pat` inputs of non-owners never reach `LED`.
- **Reset** (async, any state, mid-grant included):
  - `LED`=0000, `gnt`=000, `owner`=3, `tick`=0.
  - Prescaler=0, `hold_cnt`=0, `rel_pend`=0.
  - `last`=2, so source 0 wins first; state=IDLE.

## Timing
- **Grant latency:** a request sampled high at edge t (in IDLE) gives `gnt`/`owner` valid after edge t. The first `LED`=`pat[owner]` appears after edge t+1.
- **Pattern latency in OWNED:** `pat` change → `LED` change in exactly 1 clk.
- **Release:**
  - A release condition true at edge t (with `hold_cnt` ≥ MIN_HOLD) clears `gnt` after edge t.
  - `LED`=0000 after edge t+1.
  - IDLE is entered after the first `tick` following entry to GAP.
- **Same-edge events:**
  - `tick` bringing `hold_cnt` to MIN_HOLD, coinciding with a release: release honoured at that edge.
  - `tick` reaching MAX_HOLD with a competitor present: forced release at that edge.
- **Widths:**
  - Prescaler: ceil(log2(TICK_DIV)) bits.
  - `hold_cnt`: ceil(log2(MAX_HOLD+1)) bits, saturating, never wraps.

## Configuration
- `LED_ARB_BLANK_EN`
  - **Defined:** the GAP state exists as described, blanking the bank for up to one tick between owners.
  - **Undefined:** GAP is removed. Release goes straight to IDLE, `LED` keeps the old pattern, and a pending request is granted on the following edge (1-clk handover). All other behaviour is unchanged.

## Test plan
Parameters for all scenarios: TICK_DIV=4, MIN_HOLD=2, MAX_HOLD=4, `LED_ARB_BLANK_EN` defined.

1. Reset, then `req`=111 → `gnt`=001 and `owner`=0 one edge later; `LED`=`pat0` on the next edge.
2. Owner 0 pulses `rel` 1 tick after grant → grant held until `hold_cnt`=2, then `gnt`=000. `LED`=0000 for the GAP, then `gnt`=010 (round robin).
3. Source 1 holds `req` while source 2 requests → forced release at `hold_cnt`=4 (16 clks), then grant to source 2. Source 1 alone holding `req` → grant retained beyond 4 ticks.
4. `pat1` changes 0001→1000 while owned → `LED` follows exactly 1 clk later. Changing `pat0`/`pat2` (non-owners) → `LED` unaffected. `rel[2]` pulse → ignored.
5. `rst` asserted mid-grant (asynchronous, between clk edges) → `LED`=0000, `gnt`=000, `owner`=3, `tick`=0 immediately. After release with `req`=110, source 1 is granted.
6. `LED_ARB_BLANK_EN` undefined: release of source 0 with `req[1]` pending → `gnt` 001→000→010 on consecutive edges, and `LED` never shows 0000.
